// File: rtl/hash_pkg.sv
// ============================================================================
// Module      : hash_pkg
// Description : Shared constants, controller state encoding and a sizing
//               helper for the XOR-fold hash datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hash_pkg;

    localparam int HASH_BLOCK_W  = 512;
    localparam int HASH_DIGEST_W = 8;
    localparam int HASH_CNT_W    = 16;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HASH = 2'd1,
        DONE = 2'd2
    } hash_ctrl_state_t;

    // Slot counter width; a one-word block still gets a 1-bit counter.
    function automatic int idx_width(input int wpb);
        return (wpb > 1) ? $clog2(wpb) : 1;
    endfunction

endpackage : hash_pkg

`default_nettype wire

// File: rtl/xor_hash.sv
// ============================================================================
// Module      : xor_hash
// Description : Combinational XOR fold of a 512-bit block down to 8 bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_hash
    import hash_pkg::*;
(
    input  logic [HASH_BLOCK_W-1:0]  block,
    output logic [HASH_DIGEST_W-1:0] digest
);

    localparam int c_NBYTES = HASH_BLOCK_W / HASH_DIGEST_W;

    logic [HASH_DIGEST_W-1:0] w_fold;

    always_comb begin
        w_fold = '0;
        for (int i = 0; i < c_NBYTES; i++) begin
            w_fold = w_fold ^ block[i*HASH_DIGEST_W +: HASH_DIGEST_W];
        end
    end

    assign digest = w_fold;

endmodule : xor_hash

`default_nettype wire

// File: rtl/xor_hash_ctrl.sv
// ============================================================================
// Module      : xor_hash_ctrl
// Description : Packs a word stream into 512-bit blocks, hashes each block and
//               chains the results into a per-message digest.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_hash_ctrl
    import hash_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W-1:0]        in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [HASH_DIGEST_W-1:0] out_digest,
    output logic [HASH_CNT_W-1:0]    out_blocks
);

    localparam int c_WPB   = HASH_BLOCK_W / WORD_W;
    localparam int c_IDX_W = idx_width(c_WPB);

    hash_ctrl_state_t           r_state;
    logic [HASH_BLOCK_W-1:0]    r_buf;
    logic [c_IDX_W-1:0]         r_idx;
    logic [HASH_DIGEST_W-1:0]   r_acc;
    logic [HASH_CNT_W-1:0]      r_blocks;
    logic                       r_last_pend;

    logic [HASH_DIGEST_W-1:0]   w_blk_hash;
    logic                       w_accept;
    logic                       w_slot_end;

    xor_hash u_xor_hash (
        .block  (r_buf),
        .digest (w_blk_hash)
    );

    // Handshake readiness is a pure state decode: no input reaches it.
    assign in_ready   = (r_state == FILL);
    assign out_valid  = (r_state == DONE);
    assign out_digest = r_acc;
    assign out_blocks = r_blocks;

    assign w_accept   = in_valid && (r_state == FILL);
    assign w_slot_end = (r_idx == c_IDX_W'(c_WPB - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_buf       <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_blocks    <= '0;
            r_last_pend <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        for (int s = 0; s < c_WPB; s++) begin
                            if (r_idx == c_IDX_W'(s)) begin
                                r_buf[s*WORD_W +: WORD_W] <= in_data;
                            end
                        end
                        r_idx <= r_idx + c_IDX_W'(1);
                        if (w_slot_end || in_last) begin
                            r_state     <= HASH;
                            r_last_pend <= in_last;
                        end
                    end
                end

                HASH: begin
                    r_acc <= r_acc ^ w_blk_hash;
                    if (r_blocks != {HASH_CNT_W{1'b1}}) begin
                        r_blocks <= r_blocks + HASH_CNT_W'(1);
                    end
                    // Clearing here is what zero-pads a short final block.
                    r_buf   <= '0;
                    r_idx   <= '0;
                    r_state <= r_last_pend ? DONE : FILL;
                end

                DONE: begin
                    if (out_ready) begin
                        r_acc       <= '0;
                        r_blocks    <= '0;
                        r_last_pend <= 1'b0;
                        r_state     <= FILL;
                    end
                end

                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

endmodule : xor_hash_ctrl

`default_nettype wire
